// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared constants and state encoding for the serial adder
//
// Purpose : holds the default operand width and the FSM state encoding used by
//           serial_adder.
// Contents: DEFAULT_WIDTH  default operand width in bits
//           state_t        IDLE=0, RUN=1, DONE=2
// Config  : SERIAL_ADDER_SUB_EN (not referenced here)
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_bit_cell.sv
// rtl/serial_bit_cell.sv - one-bit full adder / full subtractor cell
//
// Purpose : combinational per-bit logic of the serial adder.
// Ports   : x    in   operand bit from a
//           y    in   operand bit from b
//           cin  in   incoming carry (borrow when subtracting)
//           sub  in   1 = subtract (only with SERIAL_ADDER_SUB_EN)
//           s    out  sum / difference bit
//           cout out  outgoing carry (borrow when subtracting)
// Config  : SERIAL_ADDER_SUB_EN adds the sub port and the borrow chain.
module serial_bit_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic sub,
`endif
  output logic s,
  output logic cout
);

  logic w_xy;
  logic w_carry;

  // Sum and difference bits are the same three-input parity.
  assign w_xy    = x ^ y;
  assign s       = w_xy ^ cin;
  assign w_carry = (x & y) | (w_xy & cin);

`ifdef SERIAL_ADDER_SUB_EN
  logic w_borrow;
  assign w_borrow = (~x & y) | (~w_xy & cin);
  assign cout     = sub ? w_borrow : w_carry;
`else
  assign cout     = w_carry;
`endif

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder (optional subtractor), LSB first, one bit per clock
//
// Purpose : adds two WIDTH-bit operands over WIDTH clocks and reports {cout,sum}.
// Ports   : clk   in   rising-edge clock
//           rst   in   asynchronous active-high reset
//           start in   begin an operation (accepted in IDLE or DONE)
//           a, b  in   operands, captured when start is accepted
//           sub   in   1 = a-b (only with SERIAL_ADDER_SUB_EN)
//           busy  out  high while the operation runs
//           done  out  one-cycle completion pulse
//           sum   out  result, updated only on completion
//           cout  out  final carry (borrow when subtracting)
// Config  : SERIAL_ADDER_SUB_EN enables the sub port and subtraction.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  // r_a doubles as the result shift register: each consumed operand bit
  // leaves at the bottom while the new result bit enters at the top.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_done;
`ifdef SERIAL_ADDER_SUB_EN
  logic             r_sub;
`endif

  logic w_s;
  logic w_c;

  serial_bit_cell u_cell (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .cin  (r_carry),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (r_sub),
`endif
    .s    (w_s),
    .cout (w_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub   <= sub;
`endif
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= {w_s, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            // Last bit: publish the shifted-in result including this bit.
            r_sum   <= {w_s, r_a[WIDTH-1:1]};
            r_cout  <= w_c;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts);
    a     = ta;
    b     = tb;
    sub   = ts;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat = clock edges after the accepting edge until done is seen.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat      = 0;
    busy_cyc = 0;
    while (!done && lat < 50) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[4] = '{
    '{8'hFF, 8'hFF, 8'hFE, 1'b1},
    '{8'h00, 8'h00, 8'h00, 1'b0},
    '{8'hA5, 8'h5A, 8'hFF, 1'b0},
    '{8'h80, 8'h80, 8'h00, 1'b1}
  };

  initial begin
    int lat;
    int bc;
    int pulses;
    logic [7:0] seen_sum;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sub   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic add with latency and busy duration.
    start_op(8'h05, 8'h03, 1'b0);
    check("add_busy_after_start", 32'(busy), 32'd1);
    wait_done(lat, bc);
    check("add_latency", 32'(lat), 32'd8);
    check("add_busy_cycles", 32'(bc), 32'd8);
    check("add_sum", 32'(sum), 32'h08);
    check("add_cout", 32'(cout), 32'd0);
    @(negedge clk);
    check("add_done_one_cycle", 32'(done), 32'd0);
    check("add_idle_busy", 32'(busy), 32'd0);
    check("add_sum_held", 32'(sum), 32'h08);

    // Overflow, then a back-to-back start in the DONE cycle.
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(lat, bc);
    check("ovf_sum", 32'(sum), 32'h00);
    check("ovf_cout", 32'(cout), 32'd1);
    start_op(8'h7F, 8'h01, 1'b0);
    check("b2b_done_low", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat, bc);
    check("b2b_latency", 32'(lat), 32'd8);
    check("b2b_sum", 32'(sum), 32'h80);
    check("b2b_cout", 32'(cout), 32'd0);
    @(negedge clk);

    // Start during RUN is ignored; sum keeps the previous result meanwhile.
    start_op(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a     = 8'h01;
    b     = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_sum_hidden", 32'(sum), 32'h80);
    pulses   = 0;
    seen_sum = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        seen_sum = sum;
      end
      @(negedge clk);
    end
    check("ign_pulses", 32'(pulses), 32'd1);
    check("ign_sum", 32'(seen_sum), 32'h30);

    // Asynchronous reset in cycle 4 of RUN aborts; start held high during reset.
    start_op(8'h33, 8'h44, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst   = 1'b1;
    start = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("abort_start_ignored", 32'(busy), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    start_op(8'h0A, 8'h0B, 1'b0);
    wait_done(lat, bc);
    check("post_abort_latency", 32'(lat), 32'd8);
    check("post_abort_sum", 32'(sum), 32'h15);
    check("post_abort_cout", 32'(cout), 32'd0);
    @(negedge clk);

    // Extra vectors around carry boundaries.
    for (int i = 0; i < 4; i++) begin
      start_op(vecs[i].a, vecs[i].b, 1'b0);
      wait_done(lat, bc);
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].s));
      check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].c));
      @(negedge clk);
    end

`ifdef SERIAL_ADDER_SUB_EN
    start_op(8'h03, 8'h05, 1'b1);
    wait_done(lat, bc);
    check("sub_neg_sum", 32'(sum), 32'hFE);
    check("sub_neg_borrow", 32'(cout), 32'd1);
    @(negedge clk);
    start_op(8'h05, 8'h03, 1'b1);
    wait_done(lat, bc);
    check("sub_pos_sum", 32'(sum), 32'h02);
    check("sub_pos_borrow", 32'(cout), 32'd0);
    @(negedge clk);
    start_op(8'h05, 8'h03, 1'b0);
    wait_done(lat, bc);
    check("sub0_add_sum", 32'(sum), 32'h08);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
